ibex_rf_wb_arbiter: RTL and testbench
=====================================

// Module: ibex_rf_wb_arbiter
// PURPOSE
//  Write-port scheduler for the latch register file, which has a single write port.
//  Arbitrates writebacks from EX (ALU/mult) and LSU (load return).
//  Buffers deferred EX writes and tracks in-flight/pending destination registers.
//  Drives RAW hazard flags for the two read ports so ID can stall.
// PARAMETERS
//  DataWidth  32  write data width
//  RV32E      0   1: 16 registers (4-bit address), 0: 32 registers
//  BufDepth   2   EX deferral FIFO entries, >=1
// PORTS
//  clk_int      in   1   gated core clock
//  rst_ni       in   1   reset, asynchronous, active-low
//  ex_req_i     in   1   EX writeback valid
//  ex_waddr_i   in   5   EX destination register
//  ex_wdata_i   in   DW  EX result
//  ex_gnt_o     out  1   EX write accepted this cycle
//  lsu_req_i    in   1   load data writeback valid; never back-pressured
//  lsu_waddr_i  in   5   load destination register
//  lsu_wdata_i  in   DW  load data
//  pend_set_i   in   1   load issued; mark pend_addr_i pending
//  pend_addr_i  in   5   destination of issued load
//  raddr_a_i    in   5   read port A address (from ID)
//  raddr_b_i    in   5   read port B address (from ID)
//  hazard_a_o   out  1   raddr_a_i value not yet readable
//  hazard_b_o   out  1   raddr_b_i value not yet readable
//  rf_we_o      out  1   register file write enable
//  rf_waddr_o   out  5   register file write address
//  rf_wdata_o   out  DW  register file write data
// BEHAVIOUR
//  - Address use: only the low ADDR_WIDTH bits (4 if RV32E, else 5) of every address input are used.
//  - Reset: all outputs are 0 while rst_ni is low, including rf_we_o and ex_gnt_o.
//    Reset empties the FIFO and clears pending[] and inflight_q.
//    Reset mid-operation drops all buffered writes.
//  - Port selection, combinational, 0-cycle:
//    1. lsu_req_i                 -> LSU write
//    2. else FIFO not empty       -> pop FIFO head
//    3. else ex_req_i             -> direct EX write
//    4. else                      -> rf_we_o = 0
//  - ex_gnt_o = ex_req_i & (EX written directly | FIFO not full).
//    EX is enqueued when LSU or a FIFO pop owns the port.
//    Write order of accepted EX requests is always preserved.
//  - FIFO full with a pop in the same cycle: an enqueue is allowed and the count is unchanged.
//  - x0: a write to address 0 is granted and consumes a port slot, but rf_we_o = 0.
//    pend_set_i to x0 is ignored.
//  - pending[NUM_WORDS-1:1]:
//    set by pend_set_i; cleared by a performed LSU write to the same address.
//    If set and clear hit the same address in the same cycle, set wins.
//  - inflight_q holds {valid, addr} of the previous cycle's rf write.
//    The latch RF makes data readable one cycle after the write cycle.
//  - hazard_x_o = (raddr != 0) & (pending[raddr] | any valid FIFO entry addr == raddr
//    | (inflight_q.valid & inflight_q.addr == raddr)).
//  - Rule on requesters: EX must not target an address whose pending bit is set.
//    Violating this is an assertion error, not handled.
//  - An LSU write to a non-pending address is still written; a warning assertion fires.
// STRUCTURE
//  - ibex_pkg: RF address width constants and the wb_req_t struct {addr, data}.
//  - One sub-module, ibex_rf_wb_fifo: depth BufDepth, push/pop/full/empty.
//    It exposes per-entry addr/valid for the hazard compare.
//  - The scoreboard, inflight register and port select live in the top level.
// TESTING
//  - EX only, addr 5, data 0xA5A5A5A5, FIFO empty -> same-cycle rf_we_o=1, ex_gnt_o=1.
//    Next cycle hazard on raddr 5; cleared 2 cycles after the write.
//  - LSU addr 3 and EX addr 4 same cycle -> LSU written cycle 0, EX buffered and written cycle 1.
//    hazard_a_o(4)=1 through cycle 2.
//  - LSU held valid 3 cycles with BufDepth=2, EX valid every cycle -> two EX grants, third ex_gnt_o=0.
//    After LSU drops, FIFO drains in arrival order.
//  - pend_set_i addr 7 and LSU write addr 7 same cycle -> pending[7] stays 1; hazard persists.
//  - Write to x0 from EX and LSU -> rf_we_o=0 and slot consumed; pend_set_i(0) leaves hazards 0.
//  - rst_ni low with FIFO at 2 entries and pending[9]=1 -> FIFO empty, hazards 0, rf_we_o=0.
//    First EX after release is written directly.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared register-file writeback types.
// Address widths and the write request bundle.
package ibex_pkg;

  localparam int unsigned RegAddrW  = 5;
  localparam int unsigned RegAddrWE = 4;
  localparam int unsigned WbDataW   = 32;

  typedef struct packed {
    logic [RegAddrW-1:0] addr;
    logic [WbDataW-1:0]  data;
  } wb_req_t;

  function automatic int unsigned rf_addr_w(
    input bit rv32e
  );
    return rv32e ? RegAddrWE : RegAddrW;
  endfunction

endpackage

// File: rtl/ibex_rf_wb_fifo.sv
// Deferral buffer for EX writebacks.
// Exposes every slot's addr/valid for hazard checks.
module ibex_rf_wb_fifo #(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2
) (
  input  logic                            clk_int,
  input  logic                            rst_ni,
  input  logic                            push_i,
  input  logic [AddrWidth-1:0]            addr_i,
  input  logic [DataWidth-1:0]            data_i,
  input  logic                            pop_i,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [AddrWidth-1:0]            head_addr_o,
  output logic [DataWidth-1:0]            head_data_o,
  output logic [Depth-1:0]                ent_valid_o,
  output logic [Depth-1:0][AddrWidth-1:0] ent_addr_o
);

  localparam int unsigned PtrW =
    (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr =
    PtrW'(Depth - 1);

  logic [Depth-1:0]                valid_q;
  logic [Depth-1:0][AddrWidth-1:0] addr_q;
  logic [Depth-1:0][DataWidth-1:0] data_q;
  logic [PtrW-1:0]                 rptr_q;
  logic [PtrW-1:0]                 wptr_q;

  function automatic logic [PtrW-1:0] inc(
    input logic [PtrW-1:0] p
  );
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign full_o      = valid_q[wptr_q];
  assign empty_o     = ~valid_q[rptr_q];
  assign head_addr_o = addr_q[rptr_q];
  assign head_data_o = data_q[rptr_q];
  assign ent_valid_o = valid_q;
  assign ent_addr_o  = addr_q;

  // Ring buffer: pop clears the head slot, push then fills the tail slot.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
    end else begin
      if (pop_i) begin
        valid_q[rptr_q] <= 1'b0;
        rptr_q          <= inc(rptr_q);
      end
      if (push_i) begin
        valid_q[wptr_q] <= 1'b1;
        addr_q[wptr_q]  <= addr_i;
        data_q[wptr_q]  <= data_i;
        wptr_q          <= inc(wptr_q);
      end
    end
  end

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Single write-port scheduler for the latch RF.
// LSU first, buffered EX next, direct EX last.
module ibex_rf_wb_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned BufDepth  = 2
) (
  input  logic                 clk_int,
  input  logic                 rst_ni,
  input  logic                 ex_req_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_gnt_o,
  input  logic                 lsu_req_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  input  logic                 pend_set_i,
  input  logic [4:0]           pend_addr_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o
);

  localparam int unsigned AW = rf_addr_w(RV32E);
  localparam int unsigned NW = 1 << AW;

  logic [AW-1:0] ex_a, lsu_a, pend_a, ra_a, ra_b;
  assign ex_a   = ex_waddr_i[AW-1:0];
  assign lsu_a  = lsu_waddr_i[AW-1:0];
  assign pend_a = pend_addr_i[AW-1:0];
  assign ra_a   = raddr_a_i[AW-1:0];
  assign ra_b   = raddr_b_i[AW-1:0];

  logic                       f_full, f_empty;
  logic                       f_push, f_pop;
  logic [AW-1:0]              f_haddr;
  logic [DataWidth-1:0]       f_hdata;
  logic [BufDepth-1:0]        f_valid;
  logic [BufDepth-1:0][AW-1:0] f_addr;

  logic                 sel_req, ex_direct, we_int;
  logic [AW-1:0]        sel_a;
  logic [DataWidth-1:0] sel_d;

  logic [NW-1:0] pend_q, pend_d;
  logic          infl_valid_q;
  logic [AW-1:0] infl_addr_q;

  ibex_rf_wb_fifo #(
    .AddrWidth (AW),
    .DataWidth (DataWidth),
    .Depth     (BufDepth)
  ) u_fifo (
    .clk_int     (clk_int),
    .rst_ni      (rst_ni),
    .push_i      (f_push),
    .addr_i      (ex_a),
    .data_i      (ex_wdata_i),
    .pop_i       (f_pop),
    .full_o      (f_full),
    .empty_o     (f_empty),
    .head_addr_o (f_haddr),
    .head_data_o (f_hdata),
    .ent_valid_o (f_valid),
    .ent_addr_o  (f_addr)
  );

  // Port owner select: buffered EX drains before new EX to keep order.
  always_comb begin
    sel_req   = 1'b0;
    sel_a     = '0;
    sel_d     = '0;
    f_pop     = 1'b0;
    ex_direct = 1'b0;
    if (lsu_req_i) begin
      sel_req = 1'b1;
      sel_a   = lsu_a;
      sel_d   = lsu_wdata_i;
    end else if (!f_empty) begin
      sel_req = 1'b1;
      sel_a   = f_haddr;
      sel_d   = f_hdata;
      f_pop   = 1'b1;
    end else if (ex_req_i) begin
      sel_req   = 1'b1;
      sel_a     = ex_a;
      sel_d     = ex_wdata_i;
      ex_direct = 1'b1;
    end
  end

  assign f_push = ex_req_i & ~ex_direct & (~f_full | f_pop);
  assign we_int = sel_req & (sel_a != '0);

  assign ex_gnt_o   = rst_ni & ex_req_i & (ex_direct | ~f_full | f_pop);
  assign rf_we_o    = rst_ni & we_int;
  assign rf_waddr_o = rst_ni ? 5'(sel_a) : 5'd0;
  assign rf_wdata_o = rst_ni ? sel_d : '0;

  // Pending scoreboard: a new load issue outranks a same-address return.
  always_comb begin
    pend_d = pend_q;
    if (lsu_req_i) pend_d[lsu_a] = 1'b0;
    if (pend_set_i) pend_d[pend_a] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Scoreboard and last-write registers.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q       <= '0;
      infl_valid_q <= 1'b0;
      infl_addr_q  <= '0;
    end else begin
      pend_q       <= pend_d;
      infl_valid_q <= we_int;
      infl_addr_q  <= sel_a;
    end
  end

  function automatic logic hazard(
    input logic [AW-1:0] ra
  );
    logic hit;
    hit = pend_q[ra] |
          (infl_valid_q & (infl_addr_q == ra));
    for (int i = 0; i < BufDepth; i++) begin
      hit = hit | (f_valid[i] & (f_addr[i] == ra));
    end
    return (ra != '0) & hit;
  endfunction

  assign hazard_a_o = rst_ni & hazard(ra_a);
  assign hazard_b_o = rst_ni & hazard(ra_b);

  // Requester rule checks.
  always_ff @(posedge clk_int) begin
    if (rst_ni && ex_req_i && ex_a != '0)
      assert (!pend_q[ex_a])
        else $error("EX targets a pending register");
    if (rst_ni && lsu_req_i && lsu_a != '0)
      assert (pend_q[lsu_a])
        else $warning("LSU writes a non-pending register");
  end

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Vector table plus write-order scoreboard
// for ibex_rf_wb_arbiter.
module tb_ibex_rf_wb_arbiter;
  import ibex_pkg::*;

  logic        clk_int = 1'b0;
  logic        rst_ni  = 1'b0;
  logic        ex_req_i = 1'b0, lsu_req_i = 1'b0;
  logic        pend_set_i = 1'b0;
  logic [4:0]  ex_waddr_i = '0, lsu_waddr_i = '0;
  logic [4:0]  pend_addr_i = '0;
  logic [4:0]  raddr_a_i = '0, raddr_b_i = '0;
  logic [31:0] ex_wdata_i = '0, lsu_wdata_i = '0;
  logic        ex_gnt_o, hazard_a_o, hazard_b_o, rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  always #5 clk_int = ~clk_int;

  ibex_rf_wb_arbiter #(
    .DataWidth (32),
    .RV32E     (1'b0),
    .BufDepth  (2)
  ) dut (
    .clk_int     (clk_int),
    .rst_ni      (rst_ni),
    .ex_req_i    (ex_req_i),
    .ex_waddr_i  (ex_waddr_i),
    .ex_wdata_i  (ex_wdata_i),
    .ex_gnt_o    (ex_gnt_o),
    .lsu_req_i   (lsu_req_i),
    .lsu_waddr_i (lsu_waddr_i),
    .lsu_wdata_i (lsu_wdata_i),
    .pend_set_i  (pend_set_i),
    .pend_addr_i (pend_addr_i),
    .raddr_a_i   (raddr_a_i),
    .raddr_b_i   (raddr_b_i),
    .hazard_a_o  (hazard_a_o),
    .hazard_b_o  (hazard_b_o),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o)
  );

  typedef struct {
    logic       lr;
    logic [4:0] la;
    logic       er;
    logic [4:0] ea;
    logic       ps;
    logic [4:0] pa;
    logic [4:0] ra;
    logic [4:0] rb;
    logic       we;
    logic [4:0] wa;
    logic       gnt;
    logic       ha;
    logic       hb;
  } vec_t;

  vec_t    vq[$];
  wb_req_t exq[$];
  int      nvec = 0;
  int      nmis = 0;
  int      row  = 0;

  function automatic vec_t mk(
    input int lr, la, er, ea, ps, pa, ra, rb,
    input int we, wa, gnt, ha, hb
  );
    vec_t v;
    v.lr = lr[0]; v.la = la[4:0];
    v.er = er[0]; v.ea = ea[4:0];
    v.ps = ps[0]; v.pa = pa[4:0];
    v.ra = ra[4:0]; v.rb = rb[4:0];
    v.we = we[0]; v.wa = wa[4:0];
    v.gnt = gnt[0]; v.ha = ha[0]; v.hb = hb[0];
    return v;
  endfunction

  function automatic logic [31:0] exd(input logic [4:0] a);
    return (a == 5'd5) ? 32'hA5A5_A5A5
                       : (32'hE000_0000 | 32'(a));
  endfunction

  function automatic logic [31:0] lsd(input logic [4:0] a);
    return 32'hD000_0000 | 32'(a);
  endfunction

  task automatic apply(input vec_t v);
    logic [8:0] got, want;
    logic [4:0] act_wa;
    wb_req_t    exp;
    lsu_req_i   = v.lr; lsu_waddr_i = v.la;
    lsu_wdata_i = lsd(v.la);
    ex_req_i    = v.er; ex_waddr_i  = v.ea;
    ex_wdata_i  = exd(v.ea);
    pend_set_i  = v.ps; pend_addr_i = v.pa;
    raddr_a_i   = v.ra; raddr_b_i   = v.rb;
    @(negedge clk_int);
    act_wa = rf_we_o ? rf_waddr_o : 5'd0;
    got  = {rf_we_o, act_wa, ex_gnt_o,
            hazard_a_o, hazard_b_o};
    want = {v.we, v.wa, v.gnt, v.ha, v.hb};
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL row%0d we/wa/gnt/ha/hb got %b/%0d/%b/%b/%b want %b/%0d/%b/%b/%b",
               row, got[8], got[7:3], got[2], got[1], got[0],
               want[8], want[7:3], want[2], want[1], want[0]);
    end
    if (v.er && v.gnt && v.ea != 5'd0)
      exq.push_back('{addr: v.ea, data: exd(v.ea)});
    if (rf_we_o) begin
      nvec++;
      if (v.lr) begin
        exp = '{addr: v.la, data: lsd(v.la)};
      end else if (exq.size() > 0) begin
        exp = exq.pop_front();
      end else begin
        exp = '{addr: 5'd0, data: 32'd0};
      end
      if ({rf_waddr_o, rf_wdata_o} !== exp) begin
        nmis++;
        $display("FAIL sb_row%0d write got %0d:%h want %0d:%h",
                 row, rf_waddr_o, rf_wdata_o, exp.addr, exp.data);
      end
    end
    @(posedge clk_int);
    #1;
    row++;
  endtask

  initial begin
    // reset held, EX driven: everything must stay 0
    apply(mk(0,0,1,2,0,0,2,0, 0,0,0,0,0));
    rst_ni = 1'b1;

    // EX only to x5
    vq.push_back(mk(0,0,1,5,0,0,5,0, 1,5,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,5,0, 0,0,0,1,0));
    vq.push_back(mk(0,0,0,0,0,0,5,0, 0,0,0,0,0));
    // LSU x3 beats EX x4; EX buffered
    vq.push_back(mk(0,0,0,0,1,3,3,0, 0,0,0,0,0));
    vq.push_back(mk(1,3,1,4,0,0,4,3, 1,3,1,0,1));
    vq.push_back(mk(0,0,0,0,0,0,4,3, 1,4,0,1,1));
    vq.push_back(mk(0,0,0,0,0,0,4,3, 0,0,0,1,0));
    vq.push_back(mk(0,0,0,0,0,0,4,3, 0,0,0,0,0));
    // LSU 3 cycles, FIFO fills, third EX refused
    vq.push_back(mk(0,0,0,0,1,10,0,0, 0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,1,11,0,0, 0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,1,12,0,0, 0,0,0,0,0));
    vq.push_back(mk(1,10,1,20,0,0,20,10, 1,10,1,0,1));
    vq.push_back(mk(1,11,1,21,0,0,20,21, 1,11,1,1,0));
    vq.push_back(mk(1,12,1,22,0,0,21,22, 1,12,0,1,0));
    vq.push_back(mk(0,0,1,22,0,0,22,20, 1,20,1,0,1));
    vq.push_back(mk(0,0,0,0,0,0,22,20, 1,21,0,1,1));
    vq.push_back(mk(0,0,0,0,0,0,22,20, 1,22,0,1,0));
    vq.push_back(mk(0,0,0,0,0,0,22,0, 0,0,0,1,0));
    vq.push_back(mk(0,0,0,0,0,0,22,0, 0,0,0,0,0));
    // set and clear of x7 in the same cycle
    vq.push_back(mk(0,0,0,0,1,7,7,0, 0,0,0,0,0));
    vq.push_back(mk(1,7,0,0,1,7,7,0, 1,7,0,1,0));
    vq.push_back(mk(0,0,0,0,0,0,7,0, 0,0,0,1,0));
    vq.push_back(mk(0,0,0,0,0,0,7,0, 0,0,0,1,0));
    vq.push_back(mk(1,7,0,0,0,0,7,0, 1,7,0,1,0));
    vq.push_back(mk(0,0,0,0,0,0,7,0, 0,0,0,1,0));
    vq.push_back(mk(0,0,0,0,0,0,7,0, 0,0,0,0,0));
    // x0 writes consume a slot without writing
    vq.push_back(mk(1,0,1,0,0,0,0,0, 0,0,1,0,0));
    vq.push_back(mk(0,0,1,6,0,0,0,6, 0,0,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,6,0, 1,6,0,1,0));
    vq.push_back(mk(0,0,0,0,1,0,6,0, 0,0,0,1,0));
    vq.push_back(mk(0,0,0,0,0,0,6,0, 0,0,0,0,0));
    // fill FIFO to 2 with x9 pending
    vq.push_back(mk(0,0,0,0,1,13,0,0, 0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,1,15,0,0, 0,0,0,0,0));
    vq.push_back(mk(1,13,1,14,1,9,0,0, 1,13,1,0,0));
    vq.push_back(mk(1,15,1,16,0,0,9,14, 1,15,1,1,1));

    foreach (vq[i]) apply(vq[i]);

    // reset mid-operation drops buffered writes
    rst_ni = 1'b0;
    exq.delete();
    apply(mk(0,0,1,17,0,0,9,14, 0,0,0,0,0));
    rst_ni = 1'b1;
    apply(mk(0,0,1,18,0,0,9,14, 1,18,1,0,0));
    apply(mk(0,0,0,0,0,0,18,16, 0,0,0,1,0));
    apply(mk(0,0,0,0,0,0,18,16, 0,0,0,0,0));

    nvec++;
    if (exq.size() != 0) begin
      nmis++;
      $display("FAIL sb_drain left %0d want 0", exq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
